// File: rtl/eco32f_pkg.sv
// Shared types and configuration checks for the eco32f iterative divider.
package eco32f_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Quotient bits per clock the step chain is built for.
  function automatic bit bpc_legal(input int bpc);
    return bpc inside {1, 2, 4};
  endfunction

endpackage

// File: rtl/eco32f_div_step.sv
// One restoring division step: shifts the next dividend bit into the partial
// remainder and shifts the resulting quotient bit into n.
module eco32f_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic [WIDTH-1:0] n_nxt
);

  logic [WIDTH:0] trial;

  // r < d always holds, so a non-negative trial fits back into WIDTH bits.
  assign trial = {r, n[WIDTH-1]} - {1'b0, d};
  assign r_nxt = trial[WIDTH] ? {r[WIDTH-2:0], n[WIDTH-1]} : trial[WIDTH-1:0];
  assign n_nxt = {n[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/eco32f_divider.sv
// Iterative signed/unsigned divider with valid/ready handshake, retiring
// BITS_PER_CYCLE quotient bits per clock through a chain of restoring steps.
module eco32f_divider
  import eco32f_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  if (!bpc_legal(BITS_PER_CYCLE) || WIDTH < 8 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("eco32f_divider: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  div_state_e      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] r_q, n_q, d_q;
  logic            quot_neg, rem_neg;
  logic            accept, y_zero;

  logic [BITS_PER_CYCLE:0][WIDTH-1:0] r_chain, n_chain;

  assign accept = (state == DIV_IDLE) && in_valid && !flush;
  assign y_zero = (in_y == '0);

  assign r_chain[0] = r_q;
  assign n_chain[0] = n_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    eco32f_div_step #(.WIDTH(WIDTH)) u_step (
      .r     (r_chain[i]),
      .n     (n_chain[i]),
      .d     (d_q),
      .r_nxt (r_chain[i+1]),
      .n_nxt (n_chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (in_valid) state_nxt = y_zero ? DIV_DONE : DIV_RUN;
        DIV_RUN:  if (cnt == CNT_LAST) state_nxt = DIV_DONE;
        DIV_DONE: if (out_ready) state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == DIV_IDLE);
    out_valid = (state == DIV_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt             <= '0;
      r_q             <= '0;
      n_q             <= '0;
      d_q             <= '0;
      quot_neg        <= 1'b0;
      rem_neg         <= 1'b0;
      out_quot        <= '0;
      out_rem         <= '0;
      out_div_by_zero <= 1'b0;
    end else if (accept) begin
      n_q      <= mag(in_x, in_signed);
      d_q      <= mag(in_y, in_signed);
      r_q      <= '0;
      cnt      <= CNT_INIT;
      quot_neg <= in_signed & (in_x[WIDTH-1] ^ in_y[WIDTH-1]);
      rem_neg  <= in_signed & in_x[WIDTH-1];
      if (y_zero) begin
        out_quot        <= '1;
        out_rem         <= in_x;
        out_div_by_zero <= 1'b1;
      end
    end else if (state == DIV_RUN && !flush) begin
      r_q <= r_chain[BITS_PER_CYCLE];
      n_q <= n_chain[BITS_PER_CYCLE];
      cnt <= cnt - CNT_LAST;
      // MIN / -1 lands here with quot_neg clear, so the magnitude passes through.
      if (cnt == CNT_LAST) begin
        out_quot        <= quot_neg ? -n_chain[BITS_PER_CYCLE] : n_chain[BITS_PER_CYCLE];
        out_rem         <= rem_neg  ? -r_chain[BITS_PER_CYCLE] : r_chain[BITS_PER_CYCLE];
        out_div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eco32f_divider.sv
// Self-checking bench: BPC=1 and BPC=4 instances share stimulus and are
// compared against a plain-arithmetic division model.
module tb_eco32f_divider;

  localparam int W  = 32;
  localparam int N1 = 32;
  localparam int N4 = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, in_signed, out_ready;
  logic [W-1:0]  in_x, in_y;
  logic          in_ready1, out_valid1, dz1;
  logic          in_ready4, out_valid4, dz4;
  logic [W-1:0]  quot1, rem1, quot4, rem4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eco32f_divider #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_x(in_x), .in_y(in_y), .in_signed(in_signed), .out_valid(out_valid1),
    .out_ready(out_ready), .out_quot(quot1), .out_rem(rem1), .out_div_by_zero(dz1)
  );

  eco32f_divider #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_x(in_x), .in_y(in_y), .in_signed(in_signed), .out_valid(out_valid4),
    .out_ready(out_ready), .out_quot(quot4), .out_rem(rem4), .out_div_by_zero(dz4)
  );

  // Reference: ordinary integer division, truncating toward zero.
  function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sx, sy;
    if (y == 0) begin
      q = '1; r = x; z = 1'b1;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = W'(sx / sy);
      r = W'(sx % sy);
      z = 1'b0;
    end else begin
      q = x / y; r = x % y; z = 1'b0;
    end
  endfunction

  // Pulse one operation with out_ready high; record latencies (cycles after the
  // accept edge) and the results of both instances.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        output int lat1, output int lat4, output int rdy1,
                        output logic [W-1:0] q1, output logic [W-1:0] r1, output logic z1,
                        output logic [W-1:0] q4, output logic [W-1:0] r4, output logic z4);
    int k;
    @(negedge clk);
    in_x = x; in_y = y; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1; lat1 = -1; lat4 = -1; rdy1 = -1;
    q1 = '0; r1 = '0; z1 = 1'b0; q4 = '0; r4 = '0; z4 = 1'b0;
    while (k < 200 && (lat1 < 0 || lat4 < 0 || rdy1 < 0)) begin
      if (lat1 >= 0 && rdy1 < 0 && in_ready1) rdy1 = k;
      if (out_valid1 && lat1 < 0) begin lat1 = k; q1 = quot1; r1 = rem1; z1 = dz1; end
      if (out_valid4 && lat4 < 0) begin lat4 = k; q4 = quot4; r4 = rem4; z4 = dz4; end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready1, out_valid1, quot1, rem1, dz1} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_dut1 got rdy=%b vld=%b q=%h r=%h z=%b", in_ready1, out_valid1, quot1, rem1, dz1);
    end
    checks++;
    if ({in_ready4, out_valid4, quot4, rem4, dz4} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_dut4 got rdy=%b vld=%b q=%h r=%h z=%b", in_ready4, out_valid4, quot4, rem4, dz4);
    end
  endtask

  // Runs one op and checks both instances' results and latencies.
  task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int lat1, lat4, rdy1, el1, el4;
    logic [W-1:0] q1, r1, q4, r4, eq, er;
    logic z1, z4, ez;
    run_op(x, y, s, lat1, lat4, rdy1, q1, r1, z1, q4, r4, z4);
    ref_div(x, y, s, eq, er, ez);
    el1 = ez ? 1 : N1 + 1;
    el4 = ez ? 1 : N4 + 1;
    checks++;
    if ({q1, r1, z1} !== {eq, er, ez}) begin
      failures++;
      $display("FAIL %s_bpc1 x=%h y=%h s=%b got q=%h r=%h z=%b exp q=%h r=%h z=%b",
               name, x, y, s, q1, r1, z1, eq, er, ez);
    end
    checks++;
    if ({q4, r4, z4} !== {eq, er, ez}) begin
      failures++;
      $display("FAIL %s_bpc4 x=%h y=%h s=%b got q=%h r=%h z=%b exp q=%h r=%h z=%b",
               name, x, y, s, q4, r4, z4, eq, er, ez);
    end
    checks++;
    if (lat1 != el1 || lat4 != el4) begin
      failures++;
      $display("FAIL %s_latency got bpc1=%0d bpc4=%0d exp bpc1=%0d bpc4=%0d", name, lat1, lat4, el1, el4);
    end
    checks++;
    if (rdy1 != el1 + 1) begin
      failures++;
      $display("FAIL %s_in_ready_return got=%0d exp=%0d", name, rdy1, el1 + 1);
    end
  endtask

  task automatic test_directed;
    check_op("u100by7",  32'd100,      32'd7,        1'b0);
    check_op("s_neg7by2", 32'hFFFFFFF9, 32'd2,       1'b1);
    check_op("dz_signed", 32'h00001234, 32'd0,       1'b1);
    check_op("dz_unsigned", 32'h00001234, 32'd0,     1'b0);
    check_op("overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check_op("u_max_by1", 32'hFFFFFFFF, 32'd1,       1'b0);
  endtask

  task automatic test_random;
    logic [W-1:0] x, y;
    logic s;
    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      case ($urandom_range(0, 4))
        0: y = $urandom;
        1: y = W'($urandom_range(1, 15));
        2: y = -W'($urandom_range(1, 15));
        3: y = '0;
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      s = 1'($urandom_range(0, 1));
      check_op("random", x, y, s);
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] q, r, eq, er;
    logic z, ez;
    int k;
    ref_div(32'd5000, 32'hFFFFFFFD, 1'b1, eq, er, ez);
    @(negedge clk);
    in_x = 32'd5000; in_y = 32'hFFFFFFFD; in_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid1 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (!out_valid1) begin
      failures++;
      $display("FAIL bp_timeout got out_valid=%b exp=1", out_valid1);
    end
    q = quot1; r = rem1; z = dz1;
    checks++;
    if ({q, r, z} !== {eq, er, ez}) begin
      failures++;
      $display("FAIL bp_result got q=%h r=%h z=%b exp q=%h r=%h z=%b", q, r, z, eq, er, ez);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({quot1, rem1, dz1, out_valid1, in_ready1, out_valid4, in_ready4} !== {q, r, z, 1'b1, 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got q=%h r=%h vld=%b rdy=%b vld4=%b rdy4=%b exp q=%h r=%h vld=1 rdy=0",
                 c, quot1, rem1, out_valid1, in_ready1, out_valid4, in_ready4, q, r);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid1, in_ready1, out_valid4, in_ready4} !== 4'b0101) begin
      failures++;
      $display("FAIL bp_release got vld=%b rdy=%b vld4=%b rdy4=%b exp vld=0 rdy=1",
               out_valid1, in_ready1, out_valid4, in_ready4);
    end
  endtask

  task automatic test_flush;
    int k;
    logic seen;
    @(negedge clk);
    in_x = 32'd123456; in_y = 32'd77; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (k = 1; k < 10; k++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({in_ready1, out_valid1, in_ready4, out_valid4} !== 4'b1010) begin
      failures++;
      $display("FAIL flush_run got rdy=%b vld=%b rdy4=%b vld4=%b exp rdy=1 vld=0",
               in_ready1, out_valid1, in_ready4, out_valid4);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen |= out_valid1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_result got out_valid_seen=%b exp=0", seen);
    end
    // flush beats a simultaneous in_valid in IDLE
    in_x = 32'h55; in_y = '0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({in_ready1, out_valid1, in_ready4, out_valid4} !== 4'b1010) begin
      failures++;
      $display("FAIL flush_idle_accept got rdy=%b vld=%b rdy4=%b vld4=%b exp rdy=1 vld=0",
               in_ready1, out_valid1, in_ready4, out_valid4);
    end
  endtask

  task automatic test_async_reset;
    check_op("pre_reset", 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    in_x = 32'd99999; in_y = 32'd3; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready1, out_valid1, quot1, rem1, dz1} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got rdy=%b vld=%b q=%h r=%h z=%b exp rdy=1 vld=0 q=0 r=0 z=0",
               in_ready1, out_valid1, quot1, rem1, dz1);
    end
    @(negedge clk);
    rst = 1'b1;
    check_op("post_reset", 32'hDEADBEEF, 32'h00001001, 1'b1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    test_directed;
    test_random;
    test_backpressure;
    test_flush;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
